// File: rtl/hash_out_mem_writer_pkg.sv
// Shared types and constants for the hash output RAM writer.
// Build option: HASH_OUT_MASK_EN (see hash_out_mem_writer.sv).
package hash_out_mem_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Ceiling log2; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

    localparam int unsigned IO_WIDTH_DEF      = 32;
    localparam int unsigned MAX_RAM_DEPTH_DEF = 16;
    localparam int unsigned LEN_WIDTH_DEF     = 32;
    localparam int unsigned MAX_OUT_BITS      = MAX_RAM_DEPTH_DEF * IO_WIDTH_DEF;
    localparam int unsigned ADDR_W            = clog2(MAX_RAM_DEPTH_DEF);

endpackage

// File: rtl/hash_out_mem_writer_if.sv
// Squeeze-word stream from the hash interface (valid/ready handshake).
interface hash_out_mem_writer_if
    import hash_out_mem_writer_pkg::*;
#(
    parameter int unsigned IO_WIDTH = IO_WIDTH_DEF
);
    logic [IO_WIDTH-1:0] data_in;
    logic                data_in_valid;
    logic                data_in_ready;

    modport master (output data_in, output data_in_valid, input data_in_ready);
    modport slave  (input data_in, input data_in_valid, output data_in_ready);
endinterface

// File: rtl/hash_out_mem_writer.sv
// Captures exactly ceil(len/IO_WIDTH) squeeze words into the output RAM, then
// requests force-done and pulses done. Build option: HASH_OUT_MASK_EN.
module hash_out_mem_writer
    import hash_out_mem_writer_pkg::*;
#(
    parameter int unsigned IO_WIDTH      = IO_WIDTH_DEF,
    parameter int unsigned MAX_RAM_DEPTH = MAX_RAM_DEPTH_DEF,
    parameter int unsigned LEN_WIDTH     = LEN_WIDTH_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_start,
    input  logic [LEN_WIDTH-1:0]             i_output_length,
    hash_out_mem_writer_if.slave             s_in,
    output logic                             o_wr_en,
    output logic [clog2(MAX_RAM_DEPTH)-1:0]  o_addr,
    output logic [IO_WIDTH-1:0]              o_wr_data,
    output logic                             o_force_done,
    input  logic                             i_force_done_ack,
    output logic                             o_busy,
    output logic                             o_len_err,
    output logic                             o_done
);

    localparam int unsigned AW       = clog2(MAX_RAM_DEPTH);
    localparam int unsigned LOG_IO   = clog2(IO_WIDTH);
    localparam int unsigned CNT_W    = clog2(MAX_RAM_DEPTH + 1);
    localparam int unsigned WORDS_W  = LEN_WIDTH - LOG_IO;
    localparam int unsigned OUT_BITS = MAX_RAM_DEPTH * IO_WIDTH;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    words_q, words_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wr_en_q, wr_en_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [IO_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                len_err_q, len_err_d;

    logic [WORDS_W-1:0]  words_full;
    logic                len_ok;
    logic                handshake;
    logic                last_word;
    logic [IO_WIDTH-1:0] word;

`ifdef HASH_OUT_MASK_EN
    logic [LOG_IO-1:0]   rem_q, rem_d;
`endif

    assign words_full = i_output_length[LEN_WIDTH-1:LOG_IO]
                      + WORDS_W'(|i_output_length[LOG_IO-1:0]);
    assign len_ok     = (i_output_length <= LEN_WIDTH'(OUT_BITS));
    assign handshake  = s_in.data_in_valid && (state_q == ST_COLLECT);
    assign last_word  = (cnt_q == words_q - CNT_W'(1));

    // Partial last word keeps only its r most-significant bits.
    always_comb begin
        word = s_in.data_in;
`ifdef HASH_OUT_MASK_EN
        if (last_word && (rem_q != '0)) begin
            word = s_in.data_in & ~({IO_WIDTH{1'b1}} >> rem_q);
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        words_d   = words_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        len_err_d = 1'b0;
`ifdef HASH_OUT_MASK_EN
        rem_d     = rem_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if (len_ok) begin
                        words_d = CNT_W'(words_full);
                        cnt_d   = '0;
`ifdef HASH_OUT_MASK_EN
                        rem_d   = i_output_length[LOG_IO-1:0];
`endif
                        state_d = (i_output_length == '0) ? ST_FLUSH : ST_COLLECT;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (handshake) begin
                    wr_en_d   = 1'b1;
                    addr_d    = cnt_q[AW-1:0];
                    wr_data_d = word;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (last_word) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (i_force_done_ack) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            words_q   <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            len_err_q <= 1'b0;
`ifdef HASH_OUT_MASK_EN
            rem_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            words_q   <= words_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            len_err_q <= len_err_d;
`ifdef HASH_OUT_MASK_EN
            rem_q     <= rem_d;
`endif
        end
    end

    assign s_in.data_in_ready = (state_q == ST_COLLECT);
    assign o_wr_en            = wr_en_q;
    assign o_addr             = addr_q;
    assign o_wr_data          = wr_data_q;
    assign o_len_err          = len_err_q;
    assign o_force_done       = (state_q == ST_FLUSH);
    assign o_done             = (state_q == ST_DONE);
    assign o_busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hash_out_mem_writer.sv
// Directed bench for hash_out_mem_writer; RAM writes are checked against a
// scoreboard filled as words are driven.
module tb_hash_out_mem_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [31:0] i_output_length;
    logic        o_wr_en;
    logic [3:0]  o_addr;
    logic [31:0] o_wr_data;
    logic        o_force_done;
    logic        i_force_done_ack;
    logic        o_busy;
    logic        o_len_err;
    logic        o_done;

    int checks = 0;
    int errors = 0;
    int writes = 0;

    logic [3:0]  exp_addr[$];
    logic [31:0] exp_data[$];

    hash_out_mem_writer_if #(.IO_WIDTH(32)) s_if ();

    hash_out_mem_writer #(
        .IO_WIDTH(32),
        .MAX_RAM_DEPTH(16),
        .LEN_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_start(i_start),
        .i_output_length(i_output_length),
        .s_in(s_if.slave),
        .o_wr_en(o_wr_en),
        .o_addr(o_addr),
        .o_wr_data(o_wr_data),
        .o_force_done(o_force_done),
        .i_force_done_ack(i_force_done_ack),
        .o_busy(o_busy),
        .o_len_err(o_len_err),
        .o_done(o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write monitor: every registered write must match the scoreboard head.
    always @(negedge clk) begin
        if (o_wr_en === 1'b1) begin
            writes++;
            chk("sb_nonempty", 64'(exp_addr.size() > 0), 64'd1);
            if (exp_addr.size() > 0) begin
                chk("wr_addr", 64'(o_addr), 64'(exp_addr.pop_front()));
                chk("wr_data", 64'(o_wr_data), 64'(exp_data.pop_front()));
            end
        end
    end

    task automatic start(input logic [31:0] len);
        writes          = 0;
        i_output_length = len;
        i_start         = 1'b1;
        step();
        i_start         = 1'b0;
    endtask

    // Drive words first..first+cnt-1 of a total-word transfer.
    task automatic feed(input int first, input int cnt, input int total, input int rem,
                        input logic [31:0] base, input bit incr, input int gap);
        logic [31:0] d;
        logic [31:0] e;
        for (int i = first; i < first + cnt; i++) begin
            d = incr ? base + 32'(i) : base;
            e = d;
`ifdef HASH_OUT_MASK_EN
            if (i == total - 1 && rem != 0) e = d & ~(32'hFFFF_FFFF >> rem);
`endif
            exp_addr.push_back(4'(i));
            exp_data.push_back(e);
            chk("ready", 64'(s_if.data_in_ready), 64'd1);
            s_if.data_in       = d;
            s_if.data_in_valid = 1'b1;
            step();
            s_if.data_in_valid = 1'b0;
            if (i != total - 1) begin
                chk("no_fd_early", 64'(o_force_done), 64'd0);
                for (int g = 0; g < gap; g++) begin
                    step();
                    if (g > 0) chk("gap_no_write", 64'(o_wr_en), 64'd0);
                end
            end
        end
    endtask

    // Currently in the first FLUSH cycle; ack is held low for ack_delay cycles.
    task automatic finish_flush(input int ack_delay, input int exp_writes);
        chk("fd_rise", 64'(o_force_done), 64'd1);
        chk("ready_low", 64'(s_if.data_in_ready), 64'd0);
        for (int k = 0; k < ack_delay; k++) begin
            step();
            chk("fd_hold", 64'(o_force_done), 64'd1);
        end
        i_force_done_ack = 1'b1;
        step();
        i_force_done_ack = 1'b0;
        chk("done_pulse", 64'(o_done), 64'd1);
        chk("fd_fall", 64'(o_force_done), 64'd0);
        chk("busy_in_done", 64'(o_busy), 64'd1);
        step();
        chk("done_clear", 64'(o_done), 64'd0);
        chk("busy_fall", 64'(o_busy), 64'd0);
        chk("nwrites", 64'(writes), 64'(exp_writes));
        chk("sb_empty", 64'(exp_addr.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b1;
        i_start            = 1'b0;
        i_output_length    = '0;
        i_force_done_ack   = 1'b0;
        s_if.data_in       = '0;
        s_if.data_in_valid = 1'b0;
        step();
        step();
        chk("rst_wr_en", 64'(o_wr_en), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_fd", 64'(o_force_done), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_ready", 64'(s_if.data_in_ready), 64'd0);
        chk("rst_addr", 64'(o_addr), 64'd0);
        rst = 1'b0;
        step();

        // len=256, continuous valid, incrementing words.
        start(32'd256);
        chk("busy_rise", 64'(o_busy), 64'd1);
        feed(0, 8, 8, 0, 32'h1, 1'b1, 0);
        finish_flush(2, 8);

        // len=100: partial last word (4 valid bits).
        start(32'd100);
        feed(0, 4, 4, 4, 32'hFFFF_FFFF, 1'b0, 0);
        finish_flush(0, 4);

        // len=128, valid 1,0,0,1,..., ack low for 5 FLUSH cycles.
        start(32'd128);
        feed(0, 4, 4, 0, 32'hA5A5_0000, 1'b1, 2);
        finish_flush(5, 4);

        // len=0: straight to FLUSH.
        start(32'd0);
        chk("zero_busy", 64'(o_busy), 64'd1);
        finish_flush(0, 0);

        // len=544 exceeds 16*32 bits.
        start(32'd544);
        chk("len_err_pulse", 64'(o_len_err), 64'd1);
        chk("len_err_busy", 64'(o_busy), 64'd0);
        step();
        chk("len_err_clear", 64'(o_len_err), 64'd0);
        chk("len_err_busy2", 64'(o_busy), 64'd0);
        chk("len_err_writes", 64'(writes), 64'd0);

        // Reset after 3 of 8 words, then a clean 2-word transfer.
        start(32'd256);
        feed(0, 3, 8, 0, 32'h1000, 1'b1, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_wr_en", 64'(o_wr_en), 64'd0);
        chk("abort_busy", 64'(o_busy), 64'd0);
        chk("abort_fd", 64'(o_force_done), 64'd0);
        chk("abort_done", 64'(o_done), 64'd0);
        chk("abort_ready", 64'(s_if.data_in_ready), 64'd0);
        chk("abort_addr", 64'(o_addr), 64'd0);
        chk("abort_data", 64'(o_wr_data), 64'd0);
        chk("abort_sb", 64'(exp_addr.size()), 64'd0);
        start(32'd64);
        feed(0, 2, 2, 0, 32'h2000, 1'b1, 0);
        finish_flush(1, 2);

        // Start pulse during COLLECT must not relatch a 2-word length.
        start(32'd128);
        feed(0, 1, 4, 0, 32'h3000, 1'b1, 0);
        i_output_length = 32'd64;
        i_start         = 1'b1;
        step();
        i_start         = 1'b0;
        chk("start_ignored_busy", 64'(o_busy), 64'd1);
        feed(1, 3, 4, 0, 32'h3000, 1'b1, 0);
        finish_flush(0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
